imem_stream_loader: RTL and testbench
=====================================

IMEM_STREAM_LOADER -- requirements
Module: imem_stream_loader

Interface
REQ-001 Parameter: DEPTH, default 512; number of 32-bit instruction memory words.
REQ-002 Parameter: ADDR_W, default 9; word address width, equal to clog2(DEPTH).
REQ-003 Parameter: NOP_WORD, default 32'h00000013; fill value (ADDI x0,x0,0).
REQ-004 Parameter: RST_HOLD, default 10; number of cycles core_rst stays high after loading ends.
REQ-005 Port: clk, input, 1; single clock, all state on rising edge.
REQ-006 Port: rst, input, 1; reset is asynchronous and active-high.
REQ-007 Port: byte_valid, input, 1; a program byte is offered this cycle.
REQ-008 Port: byte_data, input, 8; program byte, little-endian stream order.
REQ-009 Port: byte_last, input, 1; qualifies byte_data as the final byte of the stream.
REQ-010 Port: byte_ready, output, 1; the loader accepts byte_data this cycle.
REQ-011 Port: mem_we, output, 1; instruction memory write strobe.
REQ-012 Port: mem_addr, output, ADDR_W; word address of the write.
REQ-013 Port: mem_wdata, output, 32; write data.
REQ-014 Port: core_rst, output, 1; reset to the OoO core, active-high.
REQ-015 Port: load_done, output, 1; loading is complete and the core has been released.
REQ-016 Port: word_count, output, ADDR_W+1; number of program words written, saturating at DEPTH.

Function
REQ-017 Byte handshake: a byte is accepted on a rising edge where byte_valid and byte_ready are both 1.
REQ-018 FSM states: FILL, LOAD, HOLD and RUN; the state after reset is FILL.
REQ-019 FILL: mem_we=1, mem_wdata=NOP_WORD, mem_addr steps 0..DEPTH-1, one word per cycle, byte_ready=0.
REQ-020 FILL->LOAD on the cycle after address DEPTH-1 is written, so FILL lasts exactly DEPTH cycles.
REQ-021 LOAD: byte_ready=1; accepted bytes go into byte slots 0..3 (b0..b3) under a 2-bit byte index that wraps.
REQ-022 On acceptance of b3, the loader registers a write: the next cycle shows mem_we=1, mem_addr=word_ptr, mem_wdata={b3,b2,b1,b0}.
REQ-023 word_ptr and word_count increment by 1 with each program write.
REQ-024 If byte_last arrives with b3, the final word is written and the FSM goes to HOLD.
REQ-025 If byte_last arrives with b0..b2, the partial word is discarded (no write) and the FSM goes to HOLD.
REQ-026 Capacity limit: after the DEPTH-th program word is written the FSM goes to HOLD even without byte_last; byte_ready drops in the same cycle as that write.
REQ-027 Program words overwrite the NOP fill; words not written keep NOP_WORD.
REQ-028 mem_we=0 in every cycle of LOAD that has no pending word, and in every cycle of HOLD and RUN.
REQ-029 HOLD: byte_ready=0, core_rst=1, and a counter runs for exactly RST_HOLD cycles, then the FSM moves to RUN.
REQ-030 RUN: core_rst=0, load_done=1, byte_ready=0; RUN is absorbing until rst.
REQ-031 core_rst=1 in FILL, LOAD and HOLD; it deasserts only on entry to RUN.
REQ-032 byte_valid=0 in LOAD stalls the loader with no state change; there is no timeout.

Reset
REQ-033 rst=1 immediately and asynchronously forces: FSM=FILL, core_rst=1, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, load_done=0, word_count=0, byte index=0, all counters=0.
REQ-034 rst asserted mid-FILL, mid-LOAD or mid-HOLD abandons the operation; after release the loader restarts from FILL at address 0.
REQ-035 The first FILL write occurs on the first rising edge after rst deasserts.

Verification
REQ-036 Fill: release rst and hold byte_valid=0 -> 512 writes of 0x00000013 at addresses 0..511, then byte_ready=1 on cycle 513.
REQ-037 Assembly: stream 13,05,A0,00 with last on the 4th byte -> one write addr 0 data 0x00A00513; after HOLD, core_rst falls exactly 10 cycles later with load_done=1 and word_count=1.
REQ-038 Partial: stream 8 bytes, then 2 bytes with last on the 2nd -> two writes (addr 0,1), no third write, word_count=2, and addr 2 stays 0x00000013.
REQ-039 Overflow: stream 2052 bytes without last -> 512 writes, byte_ready=0 from the 512th write onward, remaining bytes never accepted, word_count=512.
REQ-040 Stall: drop byte_valid for 7 cycles between b1 and b2 -> same single write {b3,b2,b1,b0}, no extra writes.
REQ-041 Mid-reset: pulse rst during HOLD cycle 5 -> core_rst stays 1, load_done=0, and FILL restarts at addr 0.

Source files
------------

// File: rtl/imem_stream_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The slave modport is the loader; the master modport is the byte source / memory side.
interface imem_stream_loader_if #(
   parameter int unsigned ADDR_W = 9
);
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_last;
   logic              byte_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      output byte_valid,
      output byte_data,
      output byte_last,
      input  byte_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );

   modport slave (
      input  byte_valid,
      input  byte_data,
      input  byte_last,
      output byte_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );
endinterface

// File: rtl/imem_stream_loader.sv
// Fills instruction memory with NOPs, packs a little-endian byte stream into program words,
// then holds the core in reset for RST_HOLD cycles before releasing it.
module imem_stream_loader #(
   parameter int unsigned DEPTH    = 512,
   parameter int unsigned ADDR_W   = 9,
   parameter logic [31:0] NOP_WORD = 32'h0000_0013,
   parameter int unsigned RST_HOLD = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   imem_stream_loader_if.slave  bus,
   output logic                 core_rst,
   output logic                 load_done,
   output logic [ADDR_W:0]      word_count
);

   localparam int unsigned HoldW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   LastCount = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);
   localparam logic [HoldW-1:0]  HoldLast  = HoldW'(RST_HOLD - 1);

   typedef enum logic [1:0] {
      StFill,
      StLoad,
      StHold,
      StRun
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
   logic [ADDR_W-1:0] word_ptr_q, word_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [1:0]        idx_q, idx_d;
   logic [7:0]        b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic              wr_pend_q, wr_pend_d;
   logic              end_q, end_d;
   logic [HoldW-1:0]  hold_q, hold_d;

   logic              accept;
   logic              ready_int;
   logic              we_int;
   logic [ADDR_W-1:0] addr_int;
   logic [31:0]       wdata_int;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StFill;
         fill_addr_q <= '0;
         word_ptr_q  <= '0;
         count_q     <= '0;
         idx_q       <= '0;
         b0_q        <= '0;
         b1_q        <= '0;
         b2_q        <= '0;
         wr_data_q   <= '0;
         wr_pend_q   <= 1'b0;
         end_q       <= 1'b0;
         hold_q      <= '0;
      end else begin
         state_q     <= state_d;
         fill_addr_q <= fill_addr_d;
         word_ptr_q  <= word_ptr_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         b0_q        <= b0_d;
         b1_q        <= b1_d;
         b2_q        <= b2_d;
         wr_data_q   <= wr_data_d;
         wr_pend_q   <= wr_pend_d;
         end_q       <= end_d;
         hold_q      <= hold_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      fill_addr_d = fill_addr_q;
      word_ptr_d  = word_ptr_q;
      count_d     = count_q;
      idx_d       = idx_q;
      b0_d        = b0_q;
      b1_d        = b1_q;
      b2_d        = b2_q;
      wr_data_d   = wr_data_q;
      wr_pend_d   = wr_pend_q;
      end_d       = end_q;
      hold_d      = hold_q;
      accept      = 1'b0;
      ready_int   = 1'b0;
      we_int      = 1'b0;
      addr_int    = word_ptr_q;
      wdata_int   = '0;

      unique case (state_q)
         StFill: begin
            we_int    = 1'b1;
            addr_int  = fill_addr_q;
            wdata_int = NOP_WORD;
            if (fill_addr_q == LastAddr) begin
               fill_addr_d = '0;
               state_d     = StLoad;
            end else begin
               fill_addr_d = fill_addr_q + 1'b1;
            end
         end

         StLoad: begin
            // end_q marks that the word now pending is the final one: stop taking bytes.
            ready_int = ~end_q;
            accept    = bus.byte_valid & ~end_q;

            if (wr_pend_q) begin
               we_int     = 1'b1;
               wdata_int  = wr_data_q;
               word_ptr_d = word_ptr_q + 1'b1;
               wr_pend_d  = 1'b0;
               if (count_q != FullCount) begin
                  count_d = count_q + 1'b1;
               end
               if (end_q) begin
                  state_d = StHold;
               end
            end

            if (accept) begin
               idx_d = idx_q + 1'b1;
               unique case (idx_q)
                  2'd0: b0_d = bus.byte_data;
                  2'd1: b1_d = bus.byte_data;
                  2'd2: b2_d = bus.byte_data;
                  2'd3: begin
                     wr_data_d = {bus.byte_data, b2_q, b1_q, b0_q};
                     wr_pend_d = 1'b1;
                     end_d     = bus.byte_last | (count_q == LastCount);
                  end
                  default: ;
               endcase
               // A last byte that does not complete a word drops the partial word.
               if (bus.byte_last && (idx_q != 2'd3)) begin
                  idx_d   = '0;
                  state_d = StHold;
               end
            end
         end

         StHold: begin
            if (hold_q == HoldLast) begin
               hold_d  = '0;
               state_d = StRun;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end

         StRun: ;

         default: state_d = StFill;
      endcase
   end

   // The FILL write strobe is decoded from state, so it is masked while rst is held.
   assign bus.byte_ready = ready_int;
   assign bus.mem_we     = we_int & ~rst;
   assign bus.mem_addr   = addr_int;
   assign bus.mem_wdata  = rst ? 32'h0 : wdata_int;
   assign core_rst       = (state_q != StRun);
   assign load_done      = (state_q == StRun);
   assign word_count     = count_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Scenario bench for imem_stream_loader: expected writes are queued as stimulus is driven
// and matched against the writes the DUT actually issues.
module tb_imem_stream_loader;

   localparam int unsigned DEPTH    = 512;
   localparam int unsigned ADDR_W   = 9;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam int unsigned RST_HOLD = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              core_rst;
   logic              load_done;
   logic [ADDR_W:0]   word_count;

   imem_stream_loader_if #(.ADDR_W(ADDR_W)) bus_if ();

   imem_stream_loader #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .NOP_WORD (NOP),
      .RST_HOLD (RST_HOLD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus_if),
      .core_rst   (core_rst),
      .load_done  (load_done),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         obs_q[$];
   logic [31:0] tb_mem [DEPTH];
   int unsigned wr_cnt = 0;
   bit          sb_en = 1'b0;
   int          vectors = 0;
   int          miscompares = 0;

   // Instruction-memory model and write capture.
   always @(negedge clk) begin
      if (!rst && bus_if.mem_we) begin
         tb_mem[bus_if.mem_addr] = bus_if.mem_wdata;
         wr_cnt++;
         if (sb_en) obs_q.push_back(wr_t'{addr: bus_if.mem_addr, data: bus_if.mem_wdata});
      end
   end

   task automatic send_byte(input logic [7:0] d, input logic last, input int bound,
                            output bit ok);
      bus_if.byte_valid = 1'b1;
      bus_if.byte_data  = d;
      bus_if.byte_last  = last;
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (bus_if.byte_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus_if.byte_valid = 1'b0;
      bus_if.byte_last  = 1'b0;
   endtask

   // Pulse reset, release it, and count cycles until byte_ready first appears.
   task automatic start_load(output int cycles);
      sb_en = 1'b0;
      rst = 1'b1;
      bus_if.byte_valid = 1'b0;
      bus_if.byte_last  = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycles = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         cycles++;
         if (bus_if.byte_ready === 1'b1) break;
      end
      @(posedge clk);
      #1;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic wait_run(input int bound, output int cycles);
      cycles = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         cycles++;
         if (core_rst === 1'b0) break;
      end
   endtask

   task automatic test_reset();
      bus_if.byte_valid = 1'b0;
      bus_if.byte_data  = 8'h00;
      bus_if.byte_last  = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (core_rst !== 1'b1) begin
         miscompares++; $display("FAIL reset_core_rst got=%b want=1", core_rst);
      end
      vectors++;
      if (bus_if.byte_ready !== 1'b0) begin
         miscompares++; $display("FAIL reset_byte_ready got=%b want=0", bus_if.byte_ready);
      end
      vectors++;
      if (bus_if.mem_we !== 1'b0) begin
         miscompares++; $display("FAIL reset_mem_we got=%b want=0", bus_if.mem_we);
      end
      vectors++;
      if (bus_if.mem_addr !== '0 || bus_if.mem_wdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_mem_bus got=%0d/%h want=0/00000000", bus_if.mem_addr,
                  bus_if.mem_wdata);
      end
      vectors++;
      if (load_done !== 1'b0 || word_count !== '0) begin
         miscompares++;
         $display("FAIL reset_status got=%b/%0d want=0/0", load_done, word_count);
      end
   endtask

   task automatic test_fill();
      int  cyc;
      wr_t e, o;
      start_load(cyc);
      vectors++;
      if (cyc !== 513) begin
         miscompares++; $display("FAIL fill_ready_cycle got=%0d want=513", cyc);
      end
      for (int a = 0; a < DEPTH; a++) begin
         vectors++;
         if (tb_mem[a] !== NOP) begin
            miscompares++; $display("FAIL fill_word addr=%0d got=%h want=%h", a, tb_mem[a], NOP);
         end
      end
      vectors++;
      if (wr_cnt !== DEPTH) begin
         miscompares++; $display("FAIL fill_write_count got=%0d want=%0d", wr_cnt, DEPTH);
      end
      sb_en = 1'b1;
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if (bus_if.mem_we !== 1'b0 || core_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL load_idle got=we%b/crst%b want=we0/crst1", bus_if.mem_we, core_rst);
         end
      end
      @(posedge clk);
      #1;
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         vectors++; miscompares++;
         $display("FAIL load_idle_write got=%0d/%h want=none", o.addr, o.data);
      end
      e = '0;
      if (e.addr !== '0) $display("unreachable");
   endtask

   task automatic test_assembly();
      logic [7:0] pb [4] = '{8'h13, 8'h05, 8'hA0, 8'h00};
      bit  ok;
      int  cyc;
      wr_t e, o;
      sb_en = 1'b1;
      exp_q.push_back(wr_t'{addr: '0, data: 32'h00A0_0513});
      for (int k = 0; k < 4; k++) send_byte(pb[k], k == 3, 20, ok);
      wait_run(40, cyc);
      vectors++;
      if (cyc !== 12) begin
         miscompares++; $display("FAIL asm_release_cycle got=%0d want=12", cyc);
      end
      vectors++;
      if (load_done !== 1'b1 || word_count !== 10'd1) begin
         miscompares++; $display("FAIL asm_status got=%b/%0d want=1/1", load_done, word_count);
      end
      vectors++;
      if (tb_mem[0] !== 32'h00A0_0513 || tb_mem[1] !== NOP) begin
         miscompares++; $display("FAIL asm_mem got=%h/%h want=00a00513/%h", tb_mem[0], tb_mem[1], NOP);
      end
      while (exp_q.size() > 0 || obs_q.size() > 0) begin
         vectors++;
         if (exp_q.size() == 0 || obs_q.size() == 0) begin
            miscompares++;
            $display("FAIL asm_write_count got_left=%0d want_left=%0d", obs_q.size(), exp_q.size());
            exp_q.delete(); obs_q.delete();
         end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) begin
               miscompares++;
               $display("FAIL asm_write got=%0d/%h want=%0d/%h", o.addr, o.data, e.addr, e.data);
            end
         end
      end
   endtask

   task automatic test_partial();
      logic [7:0] b [10];
      bit  ok;
      int  cyc;
      wr_t e, o;
      start_load(cyc);
      sb_en = 1'b1;
      for (int k = 0; k < 10; k++) b[k] = 8'($urandom);
      for (int w = 0; w < 2; w++)
         exp_q.push_back(wr_t'{addr: ADDR_W'(w),
                               data: {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]}});
      for (int k = 0; k < 10; k++) send_byte(b[k], k == 9, 20, ok);
      wait_run(40, cyc);
      vectors++;
      if (core_rst !== 1'b0 || load_done !== 1'b1) begin
         miscompares++; $display("FAIL part_release got=%b/%b want=0/1", core_rst, load_done);
      end
      vectors++;
      if (word_count !== 10'd2) begin
         miscompares++; $display("FAIL part_word_count got=%0d want=2", word_count);
      end
      vectors++;
      if (tb_mem[2] !== NOP) begin
         miscompares++; $display("FAIL part_addr2 got=%h want=%h", tb_mem[2], NOP);
      end
      while (exp_q.size() > 0 || obs_q.size() > 0) begin
         vectors++;
         if (exp_q.size() == 0 || obs_q.size() == 0) begin
            miscompares++;
            $display("FAIL part_write_count got_left=%0d want_left=%0d", obs_q.size(), exp_q.size());
            exp_q.delete(); obs_q.delete();
         end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) begin
               miscompares++;
               $display("FAIL part_write got=%0d/%h want=%0d/%h", o.addr, o.data, e.addr, e.data);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [7:0] b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      bit  ok;
      int  cyc;
      wr_t e, o;
      start_load(cyc);
      sb_en = 1'b1;
      exp_q.push_back(wr_t'{addr: '0, data: 32'hDEAD_BEEF});
      send_byte(b[0], 1'b0, 20, ok);
      send_byte(b[1], 1'b0, 20, ok);
      repeat (7) begin
         @(negedge clk);
         vectors++;
         if (bus_if.byte_ready !== 1'b1 || bus_if.mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_idle got=rdy%b/we%b want=rdy1/we0", bus_if.byte_ready,
                     bus_if.mem_we);
         end
         @(posedge clk);
         #1;
      end
      send_byte(b[2], 1'b0, 20, ok);
      send_byte(b[3], 1'b1, 20, ok);
      wait_run(40, cyc);
      vectors++;
      if (word_count !== 10'd1 || load_done !== 1'b1) begin
         miscompares++; $display("FAIL stall_status got=%0d/%b want=1/1", word_count, load_done);
      end
      while (exp_q.size() > 0 || obs_q.size() > 0) begin
         vectors++;
         if (exp_q.size() == 0 || obs_q.size() == 0) begin
            miscompares++;
            $display("FAIL stall_write_count got_left=%0d want_left=%0d", obs_q.size(), exp_q.size());
            exp_q.delete(); obs_q.delete();
         end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) begin
               miscompares++;
               $display("FAIL stall_write got=%0d/%h want=%0d/%h", o.addr, o.data, e.addr, e.data);
            end
         end
      end
   endtask

   task automatic test_overflow();
      logic [7:0]  b [4];
      bit          ok;
      int          cyc;
      int          acc;
      wr_t         e, o;
      start_load(cyc);
      sb_en = 1'b1;
      acc = 0;
      for (int k = 0; k < 4 * DEPTH; k++) begin
         b[k % 4] = 8'(k * 7 + 3);
         if (k % 4 == 3)
            exp_q.push_back(wr_t'{addr: ADDR_W'(k / 4), data: {b[3], b[2], b[1], b[0]}});
         send_byte(b[k % 4], 1'b0, 10, ok);
         if (ok) acc++;
      end
      vectors++;
      if (acc !== 4 * DEPTH) begin
         miscompares++; $display("FAIL ovf_accepted got=%0d want=%0d", acc, 4 * DEPTH);
      end
      @(negedge clk);
      vectors++;
      if (bus_if.mem_we !== 1'b1 || bus_if.byte_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_last_write got=we%b/rdy%b want=we1/rdy0", bus_if.mem_we,
                  bus_if.byte_ready);
      end
      @(posedge clk);
      #1;
      acc = 0;
      for (int k = 0; k < 4; k++) begin
         send_byte(8'hA5, 1'b0, 8, ok);
         if (ok) acc++;
      end
      vectors++;
      if (acc !== 0) begin
         miscompares++; $display("FAIL ovf_extra_accepted got=%0d want=0", acc);
      end
      wait_run(40, cyc);
      vectors++;
      if (word_count !== 10'(DEPTH) || load_done !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_status got=%0d/%b want=%0d/1", word_count, load_done, DEPTH);
      end
      while (exp_q.size() > 0 || obs_q.size() > 0) begin
         vectors++;
         if (exp_q.size() == 0 || obs_q.size() == 0) begin
            miscompares++;
            $display("FAIL ovf_write_count got_left=%0d want_left=%0d", obs_q.size(), exp_q.size());
            exp_q.delete(); obs_q.delete();
         end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) begin
               miscompares++;
               $display("FAIL ovf_write got=%0d/%h want=%0d/%h", o.addr, o.data, e.addr, e.data);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] b [4] = '{8'h93, 8'h00, 8'h10, 8'h00};
      bit ok;
      int cyc;
      start_load(cyc);
      for (int k = 0; k < 4; k++) send_byte(b[k], k == 3, 20, ok);
      @(negedge clk);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++;
      if (core_rst !== 1'b1 || load_done !== 1'b0) begin
         miscompares++; $display("FAIL mid_rst_status got=%b/%b want=1/0", core_rst, load_done);
      end
      vectors++;
      if (word_count !== '0 || bus_if.mem_we !== 1'b0 || bus_if.byte_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_rst_async got=%0d/we%b/rdy%b want=0/we0/rdy0", word_count,
                  bus_if.mem_we, bus_if.byte_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus_if.mem_we !== 1'b1 || bus_if.mem_addr !== '0 || bus_if.mem_wdata !== NOP) begin
         miscompares++;
         $display("FAIL mid_rst_refill got=we%b/%0d/%h want=we1/0/%h", bus_if.mem_we,
                  bus_if.mem_addr, bus_if.mem_wdata, NOP);
      end
      @(negedge clk);
      vectors++;
      if (bus_if.mem_addr !== 9'd1 || bus_if.byte_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_rst_step got=%0d/rdy%b want=1/rdy0", bus_if.mem_addr,
                  bus_if.byte_ready);
      end
      repeat (20) @(negedge clk);
      vectors++;
      if (load_done !== 1'b0 || core_rst !== 1'b1) begin
         miscompares++; $display("FAIL mid_rst_hold got=%b/%b want=0/1", load_done, core_rst);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_assembly();
      test_partial();
      test_stall();
      test_overflow();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
